// File: rtl/tmds_decoder.sv
// TMDS receive decoder: 10b symbol to 8b pixel or 2b control code,
// with control-token word alignment that requests deserialiser bitslips.
module tmds_decoder #(
  parameter int CTRL_RUN     = 8,
  parameter int SEARCH_LIMIT = 1024,
  parameter int SLIP_HOLDOFF = 8,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_pixel,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic       o_bitslip
);

  localparam int RW = $clog2(CTRL_RUN + 1);
  localparam int WW = $clog2(SEARCH_LIMIT + 1);
  localparam int HW = $clog2(SLIP_HOLDOFF + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [RW-1:0] RUN_LAST  = RW'(CTRL_RUN - 1);
  localparam logic [WW-1:0] WIN_LAST  = WW'(SEARCH_LIMIT - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_HOLDOFF - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    SEARCH,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t        state, state_n;
  logic [9:0]    sym_r;
  logic          is_tok;
  logic [1:0]    code;
  logic [7:0]    d;
  logic [7:0]    q;
  logic [RW-1:0] run_cnt, run_n;
  logic [WW-1:0] win_cnt, win_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [TW-1:0] to_cnt, to_n;
  logic          locked_n;
  logic          bitslip_n;

  // Stage 1: capture the raw symbol from the deserialiser
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sym_r <= '0;
    else       sym_r <= i_tmds;
  end

  // Control token recognition on the registered symbol
  always_comb begin
    is_tok = 1'b1;
    code   = 2'b00;
    unique case (sym_r)
      10'h354: code = 2'b00;
      10'h0AB: code = 2'b01;
      10'h154: code = 2'b10;
      10'h2AB: code = 2'b11;
      default: is_tok = 1'b0;
    endcase
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain
  always_comb begin
    d    = sym_r[9] ? ~sym_r[7:0] : sym_r[7:0];
    q    = '0;
    q[0] = d[0];
    for (int n = 1; n < 8; n++) begin
      q[n] = sym_r[8] ? (d[n] ^ d[n-1]) : ~(d[n] ^ d[n-1]);
    end
  end

  // Stage 2: register decoded outputs; video only flagged once aligned
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pixel <= '0;
      o_ctrl  <= '0;
      o_de    <= 1'b0;
    end else if (is_tok) begin
      o_ctrl <= code;
      o_de   <= 1'b0;
    end else begin
      o_pixel <= q;
      o_de    <= o_locked;
    end
  end

  // Alignment state, counters and registered lock/bitslip outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= SEARCH;
      run_cnt   <= '0;
      win_cnt   <= '0;
      hold_cnt  <= '0;
      to_cnt    <= '0;
      o_locked  <= 1'b0;
      o_bitslip <= 1'b0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_n;
      win_cnt   <= win_n;
      hold_cnt  <= hold_n;
      to_cnt    <= to_n;
      o_locked  <= locked_n;
      o_bitslip <= bitslip_n;
    end
  end

  // Next-state logic; a completed token run wins over a window expiry
  always_comb begin
    state_n   = state;
    run_n     = run_cnt;
    win_n     = win_cnt;
    hold_n    = hold_cnt;
    to_n      = to_cnt;
    bitslip_n = 1'b0;
    unique case (state)
      SEARCH: begin
        if (is_tok && run_cnt == RUN_LAST) begin
          state_n = LOCKED;
          run_n   = '0;
          win_n   = '0;
          to_n    = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_n   = SLIP_WAIT;
          bitslip_n = 1'b1;
          run_n     = '0;
          win_n     = '0;
          hold_n    = '0;
        end else begin
          run_n = is_tok ? run_cnt + 1'b1 : '0;
          win_n = win_cnt + 1'b1;
        end
      end
      SLIP_WAIT: begin
        if (hold_cnt == HOLD_LAST) begin
          state_n = SEARCH;
          hold_n  = '0;
          run_n   = '0;
          win_n   = '0;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          to_n = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n = SEARCH;
          to_n    = '0;
          run_n   = '0;
          win_n   = '0;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        run_n   = '0;
        win_n   = '0;
        hold_n  = '0;
        to_n    = '0;
      end
    endcase
    locked_n = (state_n == LOCKED);
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Bench for tmds_decoder: table vectors through a latency-2 scoreboard,
// plus hand sequences for lock, timeout, reset mid-slip and realignment.
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int CR = 8;
  localparam int SL = 1024;
  localparam int SH = 8;
  localparam int LT = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds = '0;
  logic [7:0] o_pixel;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic       o_bitslip;

  always #5 clk = ~clk;

  tmds_decoder #(
    .CTRL_RUN    (CR),
    .SEARCH_LIMIT(SL),
    .SLIP_HOLDOFF(SH),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_tmds   (tmds),
    .o_pixel  (o_pixel),
    .o_ctrl   (o_ctrl),
    .o_de     (o_de),
    .o_locked (o_locked),
    .o_bitslip(o_bitslip)
  );

  typedef struct {
    logic [9:0] sym;
    logic [7:0] px;
    logic [1:0] ct;
    logic       de;
  } vec_t;

  typedef struct {
    bit         chk;
    logic [7:0] px;
    logic [1:0] ct;
    logic       de;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] enc(input logic [7:0] dat, input bit inv);
    int         n1;
    logic [8:0] qm;
    n1    = $countones(dat);
    qm    = '0;
    qm[0] = dat[0];
    if (n1 > 4 || (n1 == 4 && dat[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ dat[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ dat[i];
      qm[8] = 1'b1;
    end
    return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic logic [9:0] rot(input logic [9:0] t, input int o);
    logic [9:0] w;
    for (int i = 0; i < 10; i++) w[i] = t[(i + o) % 10];
    return w;
  endfunction

  task automatic drive_now(input logic [9:0] sym, input bit chk,
                           input logic [7:0] px, input logic [1:0] ct,
                           input logic de);
    exp_t e;
    tmds  = sym;
    e.chk = chk;
    e.px  = px;
    e.ct  = ct;
    e.de  = de;
    sb.push_back(e);
  endtask

  task automatic step(input logic [9:0] sym, input bit chk,
                      input logic [7:0] px, input logic [1:0] ct,
                      input logic de);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("sb_pixel", o_pixel, e.px);
        check("sb_ctrl", o_ctrl, e.ct);
        check("sb_de", o_de, e.de);
      end
    end
    drive_now(sym, chk, px, ct, de);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] toks [4];
    logic [7:0] pix  [8];
    logic [7:0] cur_px;
    logic [1:0] cur_ct;
    logic [9:0] dsym;
    vec_t       v;
    bit         lost;
    bit         got;
    int         off;
    int         cnt;
    int         last;
    int         pulses;
    int         extra;

    toks[0] = 10'h354;
    toks[1] = 10'h0AB;
    toks[2] = 10'h154;
    toks[3] = 10'h2AB;

    // reset with random input
    repeat (6) begin
      @(negedge clk);
      tmds = 10'($urandom);
    end
    check("rst_pixel", o_pixel, 8'h00);
    check("rst_ctrl", o_ctrl, 2'b00);
    check("rst_de", o_de, 1'b0);
    check("rst_locked", o_locked, 1'b0);
    check("rst_bitslip", o_bitslip, 1'b0);

    // release and lock on 354 tokens; cleared sym_r decodes as 0xFE
    sb.delete();
    rst = 1'b0;
    drive_now(10'h354, 1'b1, 8'hFE, 2'b00, 1'b0);
    for (int k = 2; k <= 12; k++) begin
      step(10'h354, 1'b1, 8'hFE, 2'b00, 1'b0);
      if (k == 9) begin
        check("lock_early", o_locked, 1'b0);
        check("no_slip", o_bitslip, 1'b0);
      end
      if (k == 10) check("lock_on_8", o_locked, 1'b1);
    end

    // decode table
    pix[0] = 8'h00;
    pix[1] = 8'hFF;
    pix[2] = 8'h10;
    pix[3] = 8'hA5;
    for (int i = 4; i < 8; i++) pix[i] = 8'($urandom);
    cur_px = 8'hFE;
    cur_ct = 2'b00;
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 2; p++) begin
        v.sym = enc(pix[i], p[0]);
        v.px  = pix[i];
        v.ct  = cur_ct;
        v.de  = 1'b1;
        tbl.push_back(v);
      end
      cur_px = pix[i];
      cur_ct = 2'((i + 1) % 4);
      v.sym  = toks[cur_ct];
      v.px   = cur_px;
      v.ct   = cur_ct;
      v.de   = 1'b0;
      tbl.push_back(v);
    end
    foreach (tbl[i]) step(tbl[i].sym, 1'b1, tbl[i].px, tbl[i].ct, tbl[i].de);

    // 4095 data symbols then a token keep lock
    dsym = enc(8'h5A, 1'b0);
    lost = 1'b0;
    for (int j = 1; j <= LT - 1; j++) begin
      step(dsym, 1'b1, 8'h5A, cur_ct, 1'b1);
      if (!o_locked) lost = 1'b1;
    end
    for (int j = 0; j < 3; j++) begin
      step(10'h354, 1'b1, 8'h5A, 2'b00, 1'b0);
      if (!o_locked) lost = 1'b1;
    end
    cur_ct = 2'b00;
    check("hold_lock_4095", lost, 1'b0);
    check("locked_after_4095", o_locked, 1'b1);

    // 4096 data symbols drop lock, o_de forced low afterwards
    for (int j = 1; j <= LT + 4; j++) begin
      step(dsym, 1'b1, 8'h5A, cur_ct, (j <= LT) ? 1'b1 : 1'b0);
      if (j == LT + 1) check("lock_before_timeout", o_locked, 1'b1);
      if (j == LT + 2) check("lock_dropped", o_locked, 1'b0);
    end
    step(dsym, 1'b0, 8'h00, 2'b00, 1'b0);
    step(dsym, 1'b0, 8'h00, 2'b00, 1'b0);
    sb.delete();

    // reset in the cycle the bitslip pulse is high
    got = 1'b0;
    for (int j = 0; j < 3 * SL; j++) begin
      @(negedge clk);
      if (o_bitslip) begin
        got = 1'b1;
        break;
      end
      tmds = dsym;
    end
    check("slip_before_reset", got, 1'b1);
    rst = 1'b1;
    #1;
    check("async_bitslip", o_bitslip, 1'b0);
    check("async_locked", o_locked, 1'b0);
    check("async_de", o_de, 1'b0);
    check("async_pixel", o_pixel, 8'h00);
    check("async_ctrl", o_ctrl, 2'b00);
    repeat (2) @(negedge clk);

    // misaligned token stream; model slips the boundary back per pulse
    off    = 3;
    cnt    = 0;
    last   = 0;
    pulses = 0;
    rst    = 1'b0;
    tmds   = rot(10'h354, off);
    for (int j = 0; j < 5 * SL; j++) begin
      @(negedge clk);
      cnt++;
      if (o_bitslip) begin
        pulses++;
        if (pulses == 1) check("first_slip_at", cnt, SL);
        else             check("slip_spacing", cnt - last, SL + SH);
        last = cnt;
        if (off > 0) off--;
      end
      if (o_locked) break;
      tmds = rot(10'h354, off);
    end
    check("locked_after_slips", o_locked, 1'b1);
    check("slip_count", pulses, 3);

    extra = 0;
    lost  = 1'b0;
    for (int j = 0; j < 2 * (SL + SH); j++) begin
      @(negedge clk);
      if (o_bitslip) extra++;
      if (!o_locked) lost = 1'b1;
      tmds = rot(10'h354, off);
    end
    check("no_slip_when_locked", extra, 0);
    check("stay_locked", lost, 1'b0);
    check("ctrl_after_lock", o_ctrl, 2'b00);
    check("de_on_tokens", o_de, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
